// File: rtl/vga_clock_pkg.sv
// Shared definitions for the HH:MM:SS VGA clock overlay: segment tables,
// snapshot FSM states and time-field indices.
package vga_clock_pkg;

    // Snapshot/conversion sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_H = 3'd1,
        ST_CONV_M = 3'd2,
        ST_CONV_S = 3'd3,
        ST_COMMIT = 3'd4
    } conv_state_t;

    // Field indices into the per-field BCD result arrays.
    localparam int FLD_H = 0;
    localparam int FLD_M = 1;
    localparam int FLD_S = 2;

    // Seven-segment patterns, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG7 [10] = '{
        7'h7E,  // 0: abcdef
        7'h30,  // 1: bc
        7'h6D,  // 2: abdeg
        7'h79,  // 3: abcdg
        7'h33,  // 4: bcfg
        7'h5B,  // 5: acdfg
        7'h5F,  // 6: acdefg
        7'h70,  // 7: abc
        7'h7F,  // 8: abcdefg
        7'h7B   // 9: abcdfg
    };

    // Out-of-range field: middle bar only.
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment pattern for one BCD digit; non-decimal codes draw nothing.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        if (d < 4'd10) begin
            return SEG7[d];
        end
        return SEG_BLANK;
    endfunction

    // 24h -> 12h hour mapping for a valid hour (0..23).
    function automatic logic [5:0] map_12h(input logic [4:0] h);
        if (h == 5'd0) begin
            return 6'd12;
        end
        if (h > 5'd12) begin
            return {1'b0, h - 5'd12};
        end
        return {1'b0, h};
    endfunction

endpackage

// File: rtl/vga_clock_render_bcd.sv
// Sequential binary-to-BCD converter for a two-digit field (0..63).
// One subtract-by-10 per clock; values above 'limit' are flagged invalid
// and finish immediately without running the loop.
module clk_bcd_conv
    import vga_clock_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [5:0] value_in,
    input  logic [5:0] limit,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       invalid
);

    logic       running;
    logic [5:0] residue;

    // start loads a new value (and may coincide with done of the previous
    // field); while running, subtract 10 until the residue drops below 10.
    always_ff @(posedge CLK) begin
        if (RST) begin
            running <= 1'b0;
            residue <= '0;
            tens    <= '0;
            invalid <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            residue <= value_in;
            tens    <= '0;
            invalid <= (value_in > limit);
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
            end else begin
                residue <= residue - 6'd10;
                tens    <= tens + 4'd1;
            end
        end
    end

    // done is combinational so the sequencer can chain the next field
    // on the same clock it collects this one.
    assign done = running && (invalid || (residue < 6'd10));
    assign ones = residue[3:0];

endmodule

// File: rtl/vga_clock_render.sv
// HH:MM:SS seven-segment overlay for a 640x480 raster. Takes a
// frame-synchronous snapshot of the time, converts it to BCD one field at a
// time, commits all digits at once, and renders them through a two-stage
// pixel pipeline.
//
// Handshakes: i_pix_stb qualifies i_x/i_y; every pipeline register moves
// only on a strobe and holds otherwise. The converter takes 'start' as a
// one-clock load pulse and reports 'done' for exactly the clock on which
// its tens/ones/invalid outputs are final.
module vga_clock_render
    import vga_clock_pkg::*;
#(
    parameter int          X0        = 13,
    parameter int          Y0        = 136,
    parameter int          SEG_L     = 40,
    parameter int          SEG_T     = 14,
    parameter int          DIG_PITCH = 87,
    parameter int          COLON_W   = 50,
    parameter logic [11:0] FG_RGB    = 12'hF00,
    parameter logic [11:0] BG_RGB    = 12'h000,
    parameter int          BLINK     = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_pix_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_frame,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       mode_12h,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       o_busy
);

    localparam int T      = SEG_T;
    localparam int L      = SEG_L;
    localparam int CELL_H = 3 * T + 2 * L;

    // ------------------------------------------------------------------
    // Snapshot sequencer
    // ------------------------------------------------------------------
    conv_state_t state;
    logic [5:0]  sh_min;
    logic [5:0]  sh_sec;
    logic [5:0]  prev_sec;
    logic        blink_phase;
    logic [6:0]  disp_seg [6];
    logic [3:0]  f_tens   [3];
    logic [3:0]  f_ones   [3];
    logic        f_inv    [3];

    logic        conv_start;
    logic [5:0]  conv_val;
    logic [5:0]  conv_lim;
    logic        conv_done;
    logic [3:0]  conv_tens;
    logic [3:0]  conv_ones;
    logic        conv_inv;

    clk_bcd_conv u_conv (
        .CLK      (CLK),
        .RST      (RST),
        .start    (conv_start),
        .value_in (conv_val),
        .limit    (conv_lim),
        .done     (conv_done),
        .tens     (conv_tens),
        .ones     (conv_ones),
        .invalid  (conv_inv)
    );

    // Select which field the converter loads next; hours come straight from
    // the inputs on the capture clock, later fields from the shadow copies.
    always_comb begin
        conv_start = 1'b0;
        conv_val   = '0;
        conv_lim   = '0;
        case (state)
            ST_IDLE: begin
                if (i_frame) begin
                    conv_start = 1'b1;
                    conv_val   = (mode_12h && (hours <= 5'd23)) ? map_12h(hours)
                                                                : {1'b0, hours};
                    conv_lim   = 6'd23;
                end
            end
            ST_CONV_H: begin
                if (conv_done) begin
                    conv_start = 1'b1;
                    conv_val   = sh_min;
                    conv_lim   = 6'd59;
                end
            end
            ST_CONV_M: begin
                if (conv_done) begin
                    conv_start = 1'b1;
                    conv_val   = sh_sec;
                    conv_lim   = 6'd59;
                end
            end
            default: ;
        endcase
    end

    // Capture on frame, collect each field as it finishes, then commit all
    // six digits and the colon phase in a single clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            sh_min      <= '0;
            sh_sec      <= '0;
            prev_sec    <= '0;
            blink_phase <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                disp_seg[i] <= SEG_BLANK;
            end
            for (int f = 0; f < 3; f++) begin
                f_tens[f] <= '0;
                f_ones[f] <= '0;
                f_inv[f]  <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_frame) begin
                        sh_min <= minutes;
                        sh_sec <= seconds;
                        state  <= ST_CONV_H;
                        o_busy <= 1'b1;
                    end
                end
                ST_CONV_H: begin
                    if (conv_done) begin
                        f_tens[FLD_H] <= conv_tens;
                        f_ones[FLD_H] <= conv_ones;
                        f_inv[FLD_H]  <= conv_inv;
                        state         <= ST_CONV_M;
                    end
                end
                ST_CONV_M: begin
                    if (conv_done) begin
                        f_tens[FLD_M] <= conv_tens;
                        f_ones[FLD_M] <= conv_ones;
                        f_inv[FLD_M]  <= conv_inv;
                        state         <= ST_CONV_S;
                    end
                end
                ST_CONV_S: begin
                    if (conv_done) begin
                        f_tens[FLD_S] <= conv_tens;
                        f_ones[FLD_S] <= conv_ones;
                        f_inv[FLD_S]  <= conv_inv;
                        state         <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int f = 0; f < 3; f++) begin
                        disp_seg[2*f]   <= f_inv[f] ? SEG_DASH : digit_seg(f_tens[f]);
                        disp_seg[2*f+1] <= f_inv[f] ? SEG_DASH : digit_seg(f_ones[f]);
                    end
                    if ((BLINK != 0) && (sh_sec != prev_sec)) begin
                        blink_phase <= ~blink_phase;
                    end
                    prev_sec <= sh_sec;
                    state    <= ST_IDLE;
                    o_busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Geometry helpers (all ranges half-open)
    // ------------------------------------------------------------------
    function automatic int cell_left(input int k);
        return X0 + k * DIG_PITCH + (k / 2) * COLON_W;
    endfunction

    function automatic int colon_left(input int j);
        return X0 + (2 * j + 2) * DIG_PITCH + j * COLON_W;
    endfunction

    function automatic logic in_rect(input int u, input int v,
                                     input int u0, input int u1,
                                     input int v0, input int v1);
        return (u >= u0) && (u < u1) && (v >= v0) && (v < v1);
    endfunction

    function automatic logic seg_hit(input logic [6:0] seg, input int u, input int v);
        logic hit;
        hit = 1'b0;
        if (seg[6] && in_rect(u, v, T,     T + L,     0,             T))             hit = 1'b1;
        if (seg[5] && in_rect(u, v, T + L, 2 * T + L, T,             T + L))         hit = 1'b1;
        if (seg[4] && in_rect(u, v, T + L, 2 * T + L, 2 * T + L,     2 * T + 2 * L)) hit = 1'b1;
        if (seg[3] && in_rect(u, v, T,     T + L,     2 * T + 2 * L, 3 * T + 2 * L)) hit = 1'b1;
        if (seg[2] && in_rect(u, v, 0,     T,         2 * T + L,     2 * T + 2 * L)) hit = 1'b1;
        if (seg[1] && in_rect(u, v, 0,     T,         T,             T + L))         hit = 1'b1;
        if (seg[0] && in_rect(u, v, T,     T + L,     T + L,         2 * T + L))     hit = 1'b1;
        return hit;
    endfunction

    function automatic logic colon_hit(input int u, input int v);
        int du;
        du = (COLON_W - T) / 2;
        return in_rect(u, v, du, du + T, L / 2,         L / 2 + T) ||
               in_rect(u, v, du, du + T, T + L + L / 2, T + L + L / 2 + T);
    endfunction

    // ------------------------------------------------------------------
    // Pixel pipeline stage 1: locate the slot (digits 0..5, colons 6..7)
    // ------------------------------------------------------------------
    logic       s1_in_c,   s1_in;
    logic [2:0] s1_slot_c, s1_slot;
    logic [9:0] s1_u_c,    s1_u;
    logic [8:0] s1_v_c,    s1_v;

    // Map the raster position to a slot and slot-relative coordinates.
    always_comb begin
        s1_in_c   = 1'b0;
        s1_slot_c = '0;
        s1_u_c    = '0;
        s1_v_c    = '0;
        if ((int'(i_y) >= Y0) && (int'(i_y) < Y0 + CELL_H)) begin
            s1_v_c = 9'(int'(i_y) - Y0);
            for (int k = 0; k < 6; k++) begin
                if ((int'(i_x) >= cell_left(k)) && (int'(i_x) < cell_left(k) + DIG_PITCH)) begin
                    s1_in_c   = 1'b1;
                    s1_slot_c = 3'(k);
                    s1_u_c    = 10'(int'(i_x) - cell_left(k));
                end
            end
            for (int j = 0; j < 2; j++) begin
                if ((int'(i_x) >= colon_left(j)) && (int'(i_x) < colon_left(j) + COLON_W)) begin
                    s1_in_c   = 1'b1;
                    s1_slot_c = 3'(6 + j);
                    s1_u_c    = 10'(int'(i_x) - colon_left(j));
                end
            end
        end
    end

    // Stage 1 register, advances only on a pixel strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_in   <= 1'b0;
            s1_slot <= '0;
            s1_u    <= '0;
            s1_v    <= '0;
        end else if (i_pix_stb) begin
            s1_in   <= s1_in_c;
            s1_slot <= s1_slot_c;
            s1_u    <= s1_u_c;
            s1_v    <= s1_v_c;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline stage 2: segment / colon hit test and colour
    // ------------------------------------------------------------------
    logic        hit_c;
    logic [11:0] rgb_q;

    // Hit test against the committed digits and the current colon phase.
    always_comb begin
        hit_c = 1'b0;
        if (s1_in) begin
            if (s1_slot < 3'd6) begin
                hit_c = seg_hit(disp_seg[s1_slot], int'(s1_u), int'(s1_v));
            end else begin
                hit_c = blink_phase && colon_hit(int'(s1_u), int'(s1_v));
            end
        end
    end

    // Stage 2 register: colour out, held between strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rgb_q <= '0;
        end else if (i_pix_stb) begin
            rgb_q <= hit_c ? FG_RGB : BG_RGB;
        end
    end

    assign VGA_R = rgb_q[11:8];
    assign VGA_G = rgb_q[7:4];
    assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_clock_render.sv
// Bench for vga_clock_render: drives time snapshots and pixel probes and
// compares the colour output against a digit/rectangle model of the display.
module tb_vga_clock_render;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_pix_stb = 1'b0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic       i_frame = 1'b0;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [4:0] hours = '0;
    logic       mode_12h = 1'b0;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic       o_busy;

    always #5 CLK = ~CLK;

    vga_clock_render dut (
        .CLK       (CLK),
        .RST       (RST),
        .i_pix_stb (i_pix_stb),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_frame   (i_frame),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .mode_12h  (mode_12h),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .o_busy    (o_busy)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // ---------------- reference model ----------------
    // Each cell holds a digit 0..9, -1 for a dash, -2 for blank.
    string DSEG [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int mc [6];
    bit m_blink;
    int m_prev;

    task automatic model_reset();
        for (int i = 0; i < 6; i++) mc[i] = -2;
        m_blink = 1'b1;
        m_prev  = 0;
    endtask

    task automatic model_commit(input int h, input int m, input int s, input bit mode);
        int hv;
        hv = h;
        if (h > 23) begin
            mc[0] = -1; mc[1] = -1;
        end else begin
            if (mode) begin
                if (h == 0) hv = 12;
                else if (h > 12) hv = h - 12;
            end
            mc[0] = hv / 10; mc[1] = hv % 10;
        end
        if (m > 59) begin mc[2] = -1; mc[3] = -1; end
        else begin mc[2] = m / 10; mc[3] = m % 10; end
        if (s > 59) begin mc[4] = -1; mc[5] = -1; end
        else begin mc[4] = s / 10; mc[5] = s % 10; end
        if (s != m_prev) m_blink = ~m_blink;
        m_prev = s;
    endtask

    // Which segment letter (if any) covers cell-relative (u,v); T=14, L=40.
    function automatic byte seg_at(input int u, input int v);
        if (u >= 14 && u < 54 && v >= 0   && v < 14)  return "a";
        if (u >= 54 && u < 68 && v >= 14  && v < 54)  return "b";
        if (u >= 54 && u < 68 && v >= 68  && v < 108) return "c";
        if (u >= 14 && u < 54 && v >= 108 && v < 122) return "d";
        if (u >= 0  && u < 14 && v >= 68  && v < 108) return "e";
        if (u >= 0  && u < 14 && v >= 14  && v < 54)  return "f";
        if (u >= 14 && u < 54 && v >= 54  && v < 68)  return "g";
        return 8'd0;
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y);
        byte   c;
        string s;
        bit    lit;
        lit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            int left;
            left = 13 + k * 87 + (k / 2) * 50;
            if (x >= left && x < left + 87) begin
                c = seg_at(x - left, y - 136);
                if (c != 0) begin
                    if (mc[k] == -1) lit = (c == "g");
                    else if (mc[k] >= 0) begin
                        s = DSEG[mc[k]];
                        for (int i = 0; i < s.len(); i++) if (s[i] == c) lit = 1'b1;
                    end
                end
            end
        end
        for (int j = 0; j < 2; j++) begin
            int left, u, v;
            left = 13 + (2 * j + 2) * 87 + j * 50;
            u = x - left; v = y - 136;
            if (x >= left && x < left + 50 && u >= 18 && u < 32 &&
                ((v >= 20 && v < 34) || (v >= 74 && v < 88)))
                lit = m_blink;
        end
        return lit ? 12'hF00 : 12'h000;
    endfunction

    // ---------------- driver tasks ----------------
    // Present one coordinate for two strobes and return the colour.
    task automatic probe(input int x, input int y, output logic [11:0] rgb);
        @(negedge CLK);
        i_x = 10'(x); i_y = 9'(y); i_pix_stb = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        i_pix_stb = 1'b0;
        rgb = {VGA_R, VGA_G, VGA_B};
    endtask

    // Pulse i_frame with new time values and wait (bounded) for busy to drop.
    task automatic frame(input int h, input int m, input int s, input bit mode,
                         output int busy_cycles);
        @(negedge CLK);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s); mode_12h = mode;
        i_frame = 1'b1;
        @(negedge CLK);
        i_frame = 1'b0;
        busy_cycles = 0;
        while (o_busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge CLK);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [11:0] rgb;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000)
            $display("FAIL reset_rgb: got %h want 000", {VGA_R, VGA_G, VGA_B});
        else n_pass++;
        RST = 1'b0;
        model_reset();
        probe(32, 138, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL reset_blank_digit: got %h want 000", rgb); else n_pass++;
        probe(210, 161, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL reset_colon_on: got %h want F00", rgb); else n_pass++;
    endtask

    task automatic test_midnight();
        int bc;
        logic [11:0] rgb;
        frame(0, 0, 0, 1'b0, bc);
        model_commit(0, 0, 0, 1'b0);
        n_checks++;
        if (!(bc >= 1 && bc <= 20)) $display("FAIL midnight_busy: got %0d cycles want 1..20", bc); else n_pass++;
        probe(32, 138, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL midnight_seg_a: got %h want F00", rgb); else n_pass++;
        probe(32, 200, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL midnight_seg_g: got %h want 000", rgb); else n_pass++;
    endtask

    task automatic test_blink();
        int bc;
        logic [11:0] rgb;
        int sec_seq [4] = '{4, 5, 6, 6};
        logic [11:0] want [4] = '{12'h000, 12'hF00, 12'h000, 12'h000};
        for (int i = 0; i < 4; i++) begin
            frame(12, 0, sec_seq[i], 1'b0, bc);
            model_commit(12, 0, sec_seq[i], 1'b0);
            probe(210, 161, rgb);
            n_checks++;
            if (rgb !== want[i]) $display("FAIL blink_upper_%0d: got %h want %h", i, rgb, want[i]); else n_pass++;
            probe(210, 216, rgb);
            n_checks++;
            if (rgb !== want[i]) $display("FAIL blink_lower_%0d: got %h want %h", i, rgb, want[i]); else n_pass++;
        end
    endtask

    task automatic test_12h();
        int bc;
        logic [11:0] rgb;
        frame(23, 59, 59, 1'b1, bc);
        model_commit(23, 59, 59, 1'b1);
        n_checks++;
        if (!(bc >= 1 && bc <= 20)) $display("FAIL h12_busy: got %0d cycles want 1..20", bc); else n_pass++;
        probe(32, 138, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL h12_c0_a: got %h want 000", rgb); else n_pass++;
        probe(73, 166, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL h12_c0_b: got %h want F00", rgb); else n_pass++;
        probe(73, 226, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL h12_c0_c: got %h want F00", rgb); else n_pass++;
        probe(120, 138, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL h12_c1_a: got %h want 000", rgb); else n_pass++;
    endtask

    task automatic test_12h_zero();
        int bc;
        logic [11:0] rgb;
        frame(0, 7, 8, 1'b1, bc);
        model_commit(0, 7, 8, 1'b1);
        probe(73, 166, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL h12z_c0_b: got %h want F00", rgb); else n_pass++;
        probe(120, 138, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL h12z_c1_a: got %h want F00", rgb); else n_pass++;
        probe(160, 226, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL h12z_c1_c: got %h want 000", rgb); else n_pass++;
        probe(105, 226, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL h12z_c1_e: got %h want F00", rgb); else n_pass++;
    endtask

    task automatic test_invalid_sec();
        int bc;
        logic [11:0] rgb;
        int px [6] = '{481, 481, 568, 257, 344, 73};
        int py [6] = '{138, 200, 200, 138, 138, 166};
        logic [11:0] want [6] = '{12'h000, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'hF00};
        frame(10, 34, 60, 1'b0, bc);
        model_commit(10, 34, 60, 1'b0);
        for (int i = 0; i < 6; i++) begin
            probe(px[i], py[i], rgb);
            n_checks++;
            if (rgb !== want[i])
                $display("FAIL invalid_sec_px%0d (%0d,%0d): got %h want %h", i, px[i], py[i], rgb, want[i]);
            else n_pass++;
        end
        probe(330, 166, rgb);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL invalid_sec_min_f: got %h want F00", rgb); else n_pass++;
    endtask

    task automatic test_random();
        int bc, h, m, s, x, y;
        bit mode;
        logic [11:0] rgb, exp;
        for (int f = 0; f < 6; f++) begin
            h = $urandom_range(0, 31);
            m = $urandom_range(0, 63);
            s = $urandom_range(0, 63);
            mode = 1'($urandom_range(0, 1));
            frame(h, m, s, mode, bc);
            model_commit(h, m, s, mode);
            n_checks++;
            if (!(bc >= 1 && bc <= 20)) $display("FAIL rand_busy_%0d: got %0d cycles want 1..20", f, bc); else n_pass++;
            for (int p = 0; p < 12; p++) begin
                x = $urandom_range(0, 639);
                y = $urandom_range(120, 275);
                exp = model_rgb(x, y);
                probe(x, y, rgb);
                n_checks++;
                if (rgb !== exp)
                    $display("FAIL rand_pix %02d:%02d:%02d m12=%0d (%0d,%0d): got %h want %h",
                             h, m, s, mode, x, y, rgb, exp);
                else n_pass++;
                // Without a strobe the colour must hold whatever the coordinates do.
                for (int k = 0; k < 2; k++) begin
                    @(negedge CLK);
                    i_x = 10'($urandom_range(0, 639));
                    i_y = 9'($urandom_range(0, 479));
                end
                @(negedge CLK);
                n_checks++;
                if ({VGA_R, VGA_G, VGA_B} !== exp)
                    $display("FAIL rand_hold (%0d,%0d): got %h want %h", x, y, {VGA_R, VGA_G, VGA_B}, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_refire();
        int falls;
        logic prev;
        logic [11:0] rgb, exp;
        int px [5] = '{73, 32, 273, 544, 568};
        int py [5] = '{166, 138, 226, 166, 226};
        @(negedge CLK);
        hours = 5'd23; minutes = 6'd59; seconds = 6'd59; mode_12h = 1'b0;
        i_frame = 1'b1;
        @(negedge CLK);
        i_frame = 1'b0;
        repeat (4) @(negedge CLK);
        // Now in the minutes conversion: change inputs and pulse again.
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3; mode_12h = 1'b1;
        i_frame = 1'b1;
        @(negedge CLK);
        i_frame = 1'b0;
        falls = 0;
        prev  = o_busy;
        repeat (60) begin
            @(negedge CLK);
            if (prev === 1'b1 && o_busy === 1'b0) falls++;
            prev = o_busy;
        end
        n_checks++;
        if (falls !== 1) $display("FAIL refire_busy_falls: got %0d want 1", falls); else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL refire_busy_idle: got %b want 0", o_busy); else n_pass++;
        model_commit(23, 59, 59, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp = model_rgb(px[i], py[i]);
            probe(px[i], py[i], rgb);
            n_checks++;
            if (rgb !== exp) $display("FAIL refire_px%0d: got %h want %h", i, rgb, exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] rgb;
        @(negedge CLK);
        hours = 5'd23; minutes = 6'd59; seconds = 6'd59; mode_12h = 1'b0;
        i_frame = 1'b1;
        @(negedge CLK);
        i_frame = 1'b0;
        repeat (11) @(negedge CLK);
        // Seconds conversion in progress here.
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", o_busy); else n_pass++;
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000)
            $display("FAIL rstmid_rgb: got %h want 000", {VGA_R, VGA_G, VGA_B});
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (30) @(negedge CLK);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL rstmid_no_resume: got %b want 0", o_busy); else n_pass++;
        probe(73, 166, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL rstmid_blank_b: got %h want 000", rgb); else n_pass++;
        probe(568, 200, rgb);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL rstmid_blank_g: got %h want 000", rgb); else n_pass++;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_midnight();
        test_blink();
        test_12h();
        test_12h_zero();
        test_invalid_sec();
        test_random();
        test_refire();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_clock_render.md
Name: vga_clock_render

Overview:
- Parametrised successor to the fixed-geometry red-only HH:MM:SS VGA overlay.
- Sits between the time-keeping counters and the 640x480 timing generator. Consumes pixel coordinates and a frame pulse, and drives 12-bit RGB.
- Adds:
  - frame-synchronous snapshot of the time, so digits never tear mid-frame;
  - sequential binary-to-BCD conversion;
  - 12/24-hour mode;
  - invalid-value dashes;
  - blinking colon;
  - parametrised position, size and colour;
  - a registered pixel pipeline.

Parameters:
- X0, 13: left x of hours-tens digit cell.
- Y0, 136: top y of all digit cells.
- SEG_L, 40: segment length in pixels.
- SEG_T, 14: segment thickness in pixels.
- DIG_PITCH, 87: horizontal slot width per digit.
- COLON_W, 50: horizontal slot width per colon.
- FG_RGB, 12'hF00: foreground colour {R,G,B}.
- BG_RGB, 12'h000: background colour.
- BLINK, 1: 1 = colon blinks each second; 0 = colon always on.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  synchronous, active-high reset.
- i_pix_stb  in  1  pixel strobe; pipeline advances only when high.
- i_x  in  10  current pixel x.
- i_y  in  9  current pixel y.
- i_frame  in  1  one-CLK pulse at start of vertical blank.
- seconds  in  6  binary seconds.
- minutes  in  6  binary minutes.
- hours  in  5  binary hours, 0-23.
- mode_12h  in  1  1 = display hours in 12-hour form.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.
- o_busy  out  1  high while a snapshot conversion is in progress.

Behaviour:
- Reset:
  - VGA_R/G/B = 0 and o_busy = 0.
  - Displayed digit registers = blank (no segments).
  - Blink phase = 1 (colon on); previous-seconds register = 0.
  - FSM = IDLE.
- FSM states: IDLE, CONV_H, CONV_M, CONV_S, COMMIT.
  - IDLE: on i_frame, capture seconds/minutes/hours/mode_12h into shadow registers, then go to CONV_H.
  - o_busy = 1 in every state except IDLE.
  - i_frame while not IDLE is ignored; no re-capture occurs.
- CONV_x (one field per state):
  - tens = 0. While residue >= 10: subtract 10, tens+1, one subtraction per CLK. Leave the state when residue < 10.
  - Maximum 6 CLKs per field.
  - Invalid field (hours > 23; minutes or seconds > 59): skip the loop and mark the field invalid.
- 12-hour mapping, applied in CONV_H before division, valid hours only:
  - 0 -> 12.
  - 13..23 -> h-12.
  - 1..12 unchanged.
- COMMIT (one CLK):
  - Copy all six BCD digits and invalid flags atomically to the displayed registers.
  - If BLINK = 1 and captured seconds differ from previous-seconds, toggle blink phase. Then update previous-seconds.
  - Return to IDLE.
- Worst-case snapshot latency: 3*6 + 2 = 20 CLKs, far inside vertical blank.
- Geometry:
  - Cell k (0..5) left edge = X0 + k*DIG_PITCH + (k>>1)*COLON_W.
  - Colon j (0..1) slot left edge = X0 + (2j+2)*DIG_PITCH + j*COLON_W.
  - Within a cell, u = x - left and v = y - Y0. All ranges are half-open.
- Segment rectangles (u range ; v range):
  - a: [T, T+L) ; [0, T)
  - b: [T+L, 2T+L) ; [T, T+L)
  - c: [T+L, 2T+L) ; [2T+L, 2T+2L)
  - d: [T, T+L) ; [2T+2L, 3T+2L)
  - e: [0, T) ; [2T+L, 2T+2L)
  - f: [0, T) ; [T, T+L)
  - g: [T, T+L) ; [T+L, 2T+L)
- Colon dots:
  - TxT squares at u in [(COLON_W-T)/2, +T).
  - Upper dot v in [L/2, L/2+T); lower dot v in [T+L+L/2, +T).
  - Drawn only when blink phase = 1.
- Digit patterns:
  - Standard abcdefg; 1 = bc, 7 = abc, 9 includes d.
  - Invalid field: both digits show g only.
- Pixel pipeline (two stages, advancing only on i_pix_stb):
  - Stage 1 registers slot index, u, v and an in-area flag.
  - Stage 2 registers the hit and drives RGB = hit ? FG_RGB : BG_RGB.
  - Latency: 2 strobes from coordinate to colour. Outputs hold when i_pix_stb = 0.
- Commit may land at any time. Visible tearing is avoided because i_frame occurs in blanking.
- Reset mid-conversion: abort to IDLE and blank the display.

Decomposition:
- Package vga_clock_pkg:
  - SEG7 constant table (digit -> 7-bit abcdefg);
  - SEG_DASH constant;
  - FSM state enum;
  - field index constants H/M/S.
- One sub-module: clk_bcd_conv. It is the sequential subtract-by-10 converter with start/done, value_in[5:0], limit, tens/ones/invalid. It is instantiated once and reused across fields by the FSM.

Test Plan:
- Reset, then 24h 00:00:00 and pulse i_frame:
  - o_busy high for 20 CLKs or fewer.
  - Pixel (32,138), hours-tens segment a, gives RGB = F00 two strobes later.
  - Pixel (32,200), segment g, gives 000.
- hours=23, min=59, sec=59, mode_12h=1:
  - Hours show "11".
  - Segment a of cell 0 is dark; segments b and c of cell 0 are lit.
- hours=0, mode_12h=1: hours show "12".
- seconds=60: seconds cells show g only, and a pixel in cell 4 segment a is dark. Minutes and hours are unaffected.
- Colon blink: two frames with seconds 5 then 6 toggle the colon; an upper-dot pixel goes lit -> dark. With an unchanged second on the next frame, the colon stays dark.
- i_frame asserted again during CONV_M: ignored. The committed digits match the first capture; o_busy drops exactly once.
- RST during CONV_S: next CLK has o_busy = 0 and all pixels show BG.
